cic_interp: RTL

//   N-stage CIC interpolator: the transmit-side counterpart of the CIC decimator chain.

---
 rtl/cic_interp.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/cic_interp.sv
// N-stage CIC interpolator: comb chain at the input rate, zero-stuffing by R = 2**os_sel,
// integrator chain at the output rate, gain normalisation by an arithmetic right shift and
// saturation to the output width. Input and output use valid/ready handshakes.
module cic_interp #(
    parameter int unsigned IDW = 16,
    parameter int unsigned ODW = 16,
    parameter int unsigned N   = 2,
    parameter int unsigned IW  = IDW + 6 * N
) (
    input  logic           clk_div,
    input  logic           reset_n,
    input  logic [2:0]     os_sel,
    input  logic [IDW-1:0] in_data,
    input  logic           in_valid,
    output logic           in_ready,
    output logic [ODW-1:0] out_data,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           sat_pulse
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e         state_q, state_d;
    logic [2:0]     sel_q, sel_d;
    logic [5:0]     phase_q, phase_d;
    logic [IW-1:0]  dly_q [N];
    logic [IW-1:0]  dly_d [N];
    logic [IW-1:0]  comb_q, comb_d;
    logic [IW-1:0]  integ_q [N];
    logic [IW-1:0]  integ_d [N];
    logic [ODW-1:0] out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           sat_q, sat_d;

    logic           enabled;
    logic           adv;
    logic           last_phase;
    logic [6:0]     phase_last;
    logic           in_ready_int;
    logic           in_fire;
    logic [IW-1:0]  dly_in [N];
    logic [IW-1:0]  comb_out;
    logic [IW-1:0]  integ_new [N];
    logic [4:0]     shift_amt;
    logic [IW-1:0]  shifted;
    logic [IW-ODW:0] hi_bits;
    logic           clip;
    logic [ODW-1:0] clipped;

    assign enabled    = (os_sel != 3'd0) && (os_sel != 3'd7);
    assign adv        = ~out_valid_q | out_ready;
    assign phase_last = (7'd1 << sel_q) - 7'd1;
    assign last_phase = ({1'b0, phase_q} == phase_last);

    // Input handshake: always open in IDLE, only on the final zero-stuff phase in RUN.
    always_comb begin
        in_ready_int = 1'b0;
        if (enabled) begin
            if (state_q == StIdle) begin
                in_ready_int = 1'b1;
            end else begin
                in_ready_int = adv & last_phase;
            end
        end
    end

    assign in_fire  = in_valid & in_ready_int;
    // Reset gates only the port so the flops never see reset_n as data.
    assign in_ready = in_ready_int & reset_n;

    // Comb chain evaluated on the incoming sample; dly_in holds each stage's new delay value.
    always_comb begin
        logic [IW-1:0] acc;
        acc = {{(IW - IDW){in_data[IDW-1]}}, in_data};
        for (int unsigned k = 0; k < N; k++) begin
            dly_in[k] = acc;
            acc       = acc - dly_q[k];
        end
        comb_out = acc;
    end

    // Cascaded integrators: each stage adds the freshly updated value of the previous one.
    always_comb begin
        logic [IW-1:0] acc;
        acc = (phase_q == 6'd0) ? comb_q : '0;
        for (int unsigned k = 0; k < N; k++) begin
            acc          = integ_q[k] + acc;
            integ_new[k] = acc;
        end
    end

    // Remove the R**(N-1) gain, then clip to the output range.
    always_comb begin
        shift_amt = 5'((N - 1) * 32'(sel_q));
        shifted   = $signed(integ_new[N-1]) >>> shift_amt;
        hi_bits   = shifted[IW-1:ODW-1];
        clip      = !((&hi_bits) || !(|hi_bits));
        if (!clip) begin
            clipped = shifted[ODW-1:0];
        end else if (shifted[IW-1]) begin
            clipped = {1'b1, {(ODW - 1){1'b0}}};
        end else begin
            clipped = {1'b0, {(ODW - 1){1'b1}}};
        end
    end

    // Next-state logic for the control FSM, comb and integrator state and output register.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        phase_d     = phase_q;
        comb_d      = comb_q;
        dly_d       = dly_q;
        integ_d     = integ_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        sat_d       = sat_q;
        if (!enabled) begin
            state_d     = StIdle;
            sel_d       = '0;
            phase_d     = '0;
            comb_d      = '0;
            dly_d       = '{default: '0};
            integ_d     = '{default: '0};
            out_data_d  = '0;
            out_valid_d = 1'b0;
            sat_d       = 1'b0;
        end else begin
            if (in_fire) begin
                sel_d   = os_sel;
                comb_d  = comb_out;
                dly_d   = dly_in;
                phase_d = '0;
                state_d = StRun;
            end
            if (state_q == StIdle) begin
                if (adv) begin
                    // Underrun: nothing to emit, integrators hold.
                    out_valid_d = 1'b0;
                    sat_d       = 1'b0;
                end
            end else if (adv) begin
                integ_d     = integ_new;
                out_data_d  = clipped;
                out_valid_d = 1'b1;
                sat_d       = clip;
                if (!last_phase) begin
                    phase_d = phase_q + 6'd1;
                end else if (!in_fire) begin
                    state_d = StIdle;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk_div or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            sel_q       <= '0;
            phase_q     <= '0;
            comb_q      <= '0;
            dly_q       <= '{default: '0};
            integ_q     <= '{default: '0};
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            phase_q     <= phase_d;
            comb_q      <= comb_d;
            dly_q       <= dly_d;
            integ_q     <= integ_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sat_q       <= sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sat_pulse = sat_q;

endmodule
